// File: rtl/axi32_lite_arbiter.sv
// Two-requester AXI4-Lite master: round-robin grant, one single-beat transaction
// in flight, read data / response returned to the granted requester.
module axi32_lite_arbiter #(
    parameter int datawidth = 32,
    parameter int addrwidth = 8
) (
    input  logic                         s_axi_clk_in,
    input  logic                         s_axi_reset_n_in,
    input  logic [1:0]                   req_valid_in,
    output logic [1:0]                   req_ready_out,
    input  logic [1:0]                   req_wr_in,
    input  logic [2*addrwidth-1:0]       req_addr_in,
    input  logic [2*datawidth-1:0]       req_wdata_in,
    input  logic [2*(datawidth/8)-1:0]   req_wstrb_in,
    output logic [1:0]                   rsp_done_out,
    output logic [datawidth-1:0]         rsp_rdata_out,
    output logic [1:0]                   rsp_resp_out,
    output logic [addrwidth-1:0]         m_axi_awaddr_out,
    output logic                         m_axi_awvalid_out,
    input  logic                         m_axi_awready_in,
    output logic [datawidth-1:0]         m_axi_wdata_out,
    output logic [datawidth/8-1:0]       m_axi_wstrb_out,
    output logic                         m_axi_wvalid_out,
    input  logic                         m_axi_wready_in,
    input  logic [1:0]                   m_axi_bresp_in,
    input  logic                         m_axi_bvalid_in,
    output logic                         m_axi_bready_out,
    output logic [addrwidth-1:0]         m_axi_araddr_out,
    output logic                         m_axi_arvalid_out,
    input  logic                         m_axi_arready_in,
    input  logic [datawidth-1:0]         m_axi_rdata_in,
    input  logic [1:0]                   m_axi_rresp_in,
    input  logic                         m_axi_rvalid_in,
    output logic                         m_axi_rready_out
);

    localparam int sw = datawidth / 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WADDR = 3'd1;
    localparam logic [2:0] ST_WRESP = 3'd2;
    localparam logic [2:0] ST_RADDR = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;

    logic [2:0]           state_q, state_d;
    logic                 last_q, last_d;
    logic [addrwidth-1:0] addr_q, addr_d;
    logic [datawidth-1:0] wdata_q, wdata_d;
    logic [sw-1:0]        wstrb_q, wstrb_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 arvalid_q, arvalid_d;
    logic [1:0]           done_q, done_d;
    logic [datawidth-1:0] rdata_q, rdata_d;
    logic [1:0]           resp_q, resp_d;

    logic gnt_sel;
    logic accept;
    logic wr_sel;
    logic [1:0] gnt_onehot;

    // On a tie the requester that did not win last time is chosen; last_q resets
    // to 1 so requester 0 wins the first tie.
    assign gnt_sel    = (&req_valid_in) ? ~last_q : (req_valid_in[1] & ~req_valid_in[0]);
    assign gnt_onehot = gnt_sel ? 2'b10 : 2'b01;
    assign accept     = (state_q == ST_IDLE) && (|req_valid_in) && s_axi_reset_n_in;
    assign wr_sel     = gnt_sel ? req_wr_in[1] : req_wr_in[0];

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d   = state_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        done_d    = 2'b00;
        rdata_d   = rdata_q;
        resp_d    = resp_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    last_d  = gnt_sel;
                    addr_d  = gnt_sel ? req_addr_in[2*addrwidth-1:addrwidth] : req_addr_in[addrwidth-1:0];
                    wdata_d = gnt_sel ? req_wdata_in[2*datawidth-1:datawidth] : req_wdata_in[datawidth-1:0];
                    wstrb_d = gnt_sel ? req_wstrb_in[2*sw-1:sw] : req_wstrb_in[sw-1:0];
                    if (wr_sel) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RADDR;
                    end
                end
            end
            ST_WADDR: begin
                // AW and W complete independently; leave only once both are gone.
                if (m_axi_awready_in) awvalid_d = 1'b0;
                if (m_axi_wready_in)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = ST_WRESP;
            end
            ST_WRESP: begin
                if (m_axi_bvalid_in) begin
                    done_d  = last_q ? 2'b10 : 2'b01;
                    rdata_d = '0;
                    resp_d  = m_axi_bresp_in;
                    state_d = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (m_axi_arready_in) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (m_axi_rvalid_in) begin
                    done_d  = last_q ? 2'b10 : 2'b01;
                    rdata_d = m_axi_rdata_in;
                    resp_d  = m_axi_rresp_in;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge s_axi_clk_in or negedge s_axi_reset_n_in) begin
        if (!s_axi_reset_n_in) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            done_q    <= 2'b00;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    assign req_ready_out     = accept ? gnt_onehot : 2'b00;
    assign rsp_done_out      = done_q;
    assign rsp_rdata_out     = rdata_q;
    assign rsp_resp_out      = resp_q;
    assign m_axi_awaddr_out  = addr_q;
    assign m_axi_awvalid_out = awvalid_q;
    assign m_axi_wdata_out   = wdata_q;
    assign m_axi_wstrb_out   = wstrb_q;
    assign m_axi_wvalid_out  = wvalid_q;
    assign m_axi_bready_out  = (state_q == ST_WRESP);
    assign m_axi_araddr_out  = addr_q;
    assign m_axi_arvalid_out = arvalid_q;
    assign m_axi_rready_out  = (state_q == ST_RDATA);

endmodule

// File: tb/tb_axi32_lite_arbiter.sv
// Bench for axi32_lite_arbiter: bench-side AXI-Lite slave, transaction-level
// reference model compared every cycle, directed scenarios plus random traffic.
module tb_axi32_lite_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_valid = '0, req_wr = '0;
    logic [15:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic [1:0]  req_ready, rsp_done, rsp_resp;
    logic [31:0] rsp_rdata;

    logic [7:0]  awaddr, araddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
    logic [1:0]  bresp = 0, rresp = 0;
    logic [31:0] rdata = 0;

    axi32_lite_arbiter #(.datawidth(32), .addrwidth(8)) dut (
        .s_axi_clk_in(clk), .s_axi_reset_n_in(rst_n),
        .req_valid_in(req_valid), .req_ready_out(req_ready), .req_wr_in(req_wr),
        .req_addr_in(req_addr), .req_wdata_in(req_wdata), .req_wstrb_in(req_wstrb),
        .rsp_done_out(rsp_done), .rsp_rdata_out(rsp_rdata), .rsp_resp_out(rsp_resp),
        .m_axi_awaddr_out(awaddr), .m_axi_awvalid_out(awvalid), .m_axi_awready_in(awready),
        .m_axi_wdata_out(wdata), .m_axi_wstrb_out(wstrb), .m_axi_wvalid_out(wvalid),
        .m_axi_wready_in(wready), .m_axi_bresp_in(bresp), .m_axi_bvalid_in(bvalid),
        .m_axi_bready_out(bready), .m_axi_araddr_out(araddr), .m_axi_arvalid_out(arvalid),
        .m_axi_arready_in(arready), .m_axi_rdata_in(rdata), .m_axi_rresp_in(rresp),
        .m_axi_rvalid_in(rvalid), .m_axi_rready_out(rready)
    );

    int n_checks = 0, n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- bench-side slave ----------------
    int          sl_mode = 0;       // 0 zero-wait, 1 random, 2 awready 3 cycles after W
    bit          sl_b_hold = 0;
    bit          sl_force_r = 0;
    logic [31:0] sl_force_rdata = 0;
    logic [1:0]  sl_force_rresp = 0;
    logic [31:0] mem [0:255];

    initial begin : slave
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        bit got_aw, got_w, got_ar;
        logic [7:0] s_awaddr, s_araddr;
        logic [31:0] s_wdata;
        logic [3:0] s_wstrb;
        int aw_wait;
        got_aw = 0; got_w = 0; got_ar = 0; aw_wait = 0;
        s_awaddr = 0; s_araddr = 0; s_wdata = 0; s_wstrb = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        forever begin
            @(negedge clk);
            aw_hs = awvalid & awready;
            w_hs  = wvalid & wready;
            b_hs  = bvalid & bready;
            ar_hs = arvalid & arready;
            r_hs  = rvalid & rready;
            if (aw_hs) begin got_aw = 1; s_awaddr = awaddr; end
            if (w_hs) begin got_w = 1; s_wdata = wdata; s_wstrb = wstrb; aw_wait = 3; end
            if (ar_hs) begin got_ar = 1; s_araddr = araddr; end
            @(posedge clk); #2;
            if (!rst_n) begin
                got_aw = 0; got_w = 0; got_ar = 0; aw_wait = 0;
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            end else begin
                if (b_hs) bvalid = 0;
                if (r_hs) rvalid = 0;
                if (got_aw && got_w && !bvalid && !sl_b_hold && (sl_mode != 1 || $urandom_range(0, 1) == 1)) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[s_awaddr][b*8 +: 8] = s_wdata[b*8 +: 8];
                    bvalid = 1;
                    bresp  = (sl_mode == 1) ? 2'($urandom_range(0, 3)) : 2'b00;
                    got_aw = 0; got_w = 0;
                end
                if (got_ar && !rvalid && (sl_mode != 1 || $urandom_range(0, 1) == 1)) begin
                    rvalid = 1;
                    rdata  = sl_force_r ? sl_force_rdata : mem[s_araddr];
                    rresp  = sl_force_r ? sl_force_rresp : ((sl_mode == 1) ? 2'($urandom_range(0, 3)) : 2'b00);
                    got_ar = 0;
                end
                case (sl_mode)
                    1: begin
                        awready = 1'($urandom_range(0, 1));
                        wready  = 1'($urandom_range(0, 1));
                        arready = 1'($urandom_range(0, 1));
                    end
                    2: begin
                        wready = 1; arready = 1;
                        if (aw_wait > 0) begin aw_wait--; awready = (aw_wait == 0); end
                        else awready = 0;
                    end
                    default: begin awready = 1; wready = 1; arready = 1; end
                endcase
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    bit          m_busy, m_last, m_wr, m_aw_owed, m_w_owed, m_ar_owed, m_done_pend;
    int          m_g, m_done_req;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_resp;
    int          grant_log[$];
    int          done_cnt = 0;

    always @(negedge clk) begin : cmp
        logic [1:0] exp_ready, v;
        logic e_awv, e_wv, e_br, e_arv, e_rr;
        int g;
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_done_pend = 0; m_rdata = 0; m_resp = 0;
            m_aw_owed = 0; m_w_owed = 0; m_ar_owed = 0;
            check("reset_ctl", {req_ready, rsp_done, rsp_resp, awvalid, wvalid, bready, arvalid, rready}, 0);
            check("reset_data", {rsp_rdata, wdata}, 0);
            check("reset_addr", {awaddr, araddr, wstrb}, 0);
        end else begin
            v = req_valid;
            g = 0;
            exp_ready = 2'b00;
            if (!m_busy && v != 2'b00) begin
                if (v == 2'b11) g = m_last ? 0 : 1;
                else            g = v[0] ? 0 : 1;
                exp_ready = 2'(1 << g);
            end
            e_awv = m_busy && m_wr && m_aw_owed;
            e_wv  = m_busy && m_wr && m_w_owed;
            e_br  = m_busy && m_wr && !m_aw_owed && !m_w_owed;
            e_arv = m_busy && !m_wr && m_ar_owed;
            e_rr  = m_busy && !m_wr && !m_ar_owed;
            check("req_ready", req_ready, exp_ready);
            check("axi_ctl", {awvalid, wvalid, bready, arvalid, rready}, {e_awv, e_wv, e_br, e_arv, e_rr});
            if (e_awv) check("awaddr", awaddr, m_addr);
            if (e_wv)  check("wdata_wstrb", {wdata, wstrb}, {m_wdata, m_wstrb});
            if (e_arv) check("araddr", araddr, m_addr);
            check("rsp_done", rsp_done, m_done_pend ? 2'(1 << m_done_req) : 2'b00);
            check("rsp_payload", {rsp_rdata, rsp_resp}, {m_rdata, m_resp});
            if (rsp_done != 2'b00) done_cnt++;

            // advance to what the coming edge must produce
            m_done_pend = 0;
            if (e_br && bvalid) begin
                m_done_pend = 1; m_done_req = m_g; m_rdata = 0; m_resp = bresp; m_busy = 0;
            end
            if (e_rr && rvalid) begin
                m_done_pend = 1; m_done_req = m_g; m_rdata = rdata; m_resp = rresp; m_busy = 0;
            end
            if (e_awv && awready) m_aw_owed = 0;
            if (e_wv && wready)   m_w_owed  = 0;
            if (e_arv && arready) m_ar_owed = 0;
            if (exp_ready != 2'b00) begin
                m_busy = 1; m_g = g; m_last = 1'(g);
                m_wr    = req_wr[g];
                m_addr  = req_addr[g*8 +: 8];
                m_wdata = req_wdata[g*32 +: 32];
                m_wstrb = req_wstrb[g*4 +: 4];
                m_aw_owed = m_wr; m_w_owed = m_wr; m_ar_owed = !m_wr;
                grant_log.push_back(g);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        req_wr[i] = wr;
        req_addr[i*8 +: 8] = a;
        req_wdata[i*32 +: 32] = d;
        req_wstrb[i*4 +: 4] = s;
    endtask

    task automatic wait_ready(input int i);
        bit seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = req_ready[i];
        end
        check("ready_timeout", seen, 1);
    endtask

    task automatic wait_done(output logic [1:0] d);
        d = 2'b00;
        for (int k = 0; k < 80 && d == 2'b00; k++) begin
            @(negedge clk);
            d = rsp_done;
        end
        check("done_timeout", d != 2'b00, 1);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int k = 0; k < 300 && !idle; k++) begin
            tick();
            idle = !m_busy && !m_done_pend;
        end
        check("idle_timeout", idle, 1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_basic();
        logic [1:0] d;
        tick();
        set_cmd(0, 1, 8'h04, 32'hDEADBEEF, 4'hF);
        req_valid = 2'b01;
        @(negedge clk); check("t1_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        @(negedge clk);
        check("t1_awv_wv", {awvalid, wvalid}, 2'b11);
        check("t1_awaddr", awaddr, 8'h04);
        check("t1_wdata", wdata, 32'hDEADBEEF);
        @(negedge clk); check("t1_bready", bready, 1'b1);
        @(negedge clk);
        check("t1_done", rsp_done, 2'b01);
        check("t1_resp", rsp_resp, 2'b00);
        // read it back through requester 1
        tick();
        set_cmd(1, 0, 8'h04, 32'h0, 4'h0);
        req_valid = 2'b10;
        wait_ready(1);
        tick(); req_valid = 2'b00;
        @(negedge clk); check("t2_araddr", {arvalid, araddr}, {1'b1, 8'h04});
        wait_done(d);
        check("t2_done", d, 2'b10);
        check("t2_rdata", rsp_rdata, 32'hDEADBEEF);
        check("t2_resp", rsp_resp, 2'b00);
    endtask

    task automatic test_rr();
        logic [1:0] acc;
        int cnt[2];
        cnt[0] = 0; cnt[1] = 0;
        @(posedge clk); #3 rst_n = 0;
        set_cmd(0, 1, 8'h20, 32'h1000_0000, 4'hF);
        set_cmd(1, 1, 8'h40, 32'h2000_0000, 4'hF);
        req_valid = 2'b11;
        grant_log.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int c = 0; c < 300 && (cnt[0] < 4 || cnt[1] < 4); c++) begin
            @(negedge clk); acc = req_ready;
            tick();
            for (int i = 0; i < 2; i++) if (acc[i]) begin
                cnt[i]++;
                if (cnt[i] < 4) set_cmd(i, 1, 8'(32 + i*32 + cnt[i]*4), $urandom, 4'hF);
                else req_valid[i] = 0;
            end
        end
        check("t3_all_accepted", {cnt[0] == 4, cnt[1] == 4}, 2'b11);
        wait_idle();
        check("t3_grant_count", grant_log.size(), 8);
        for (int k = 0; k < grant_log.size(); k++) check("t3_grant_order", grant_log[k], k % 2);
    endtask

    task automatic test_aw_delay();
        int d0;
        sl_mode = 2;
        tick(); tick();
        set_cmd(0, 1, 8'h08, 32'hCAFEF00D, 4'h5);
        req_valid = 2'b01;
        wait_ready(0);
        tick(); req_valid = 2'b00;
        d0 = done_cnt;
        @(negedge clk); check("t4_cycle1", {awvalid, wvalid}, 2'b11);
        @(negedge clk); check("t4_cycle2", {awvalid, wvalid}, 2'b10);
        @(negedge clk); check("t4_cycle3", {awvalid, wvalid, awaddr}, {2'b10, 8'h08});
        wait_idle();
        check("t4_one_done", done_cnt - d0, 1);
        sl_mode = 0;
    endtask

    task automatic test_rresp();
        logic [1:0] d;
        sl_force_r = 1; sl_force_rdata = 32'h12345678; sl_force_rresp = 2'b10;
        tick();
        set_cmd(0, 0, 8'h10, 32'h0, 4'h0);
        req_valid = 2'b01;
        wait_ready(0);
        tick(); req_valid = 2'b00;
        wait_done(d);
        check("t5_done", d, 2'b01);
        check("t5_rdata", rsp_rdata, 32'h12345678);
        check("t5_resp", rsp_resp, 2'b10);
        wait_idle();
        sl_force_r = 0;
    endtask

    task automatic test_reset();
        bit seen = 0;
        int d0;
        sl_b_hold = 1;
        tick();
        set_cmd(1, 1, 8'h0C, 32'hA5A5A5A5, 4'hF);
        req_valid = 2'b10;
        wait_ready(1);
        tick(); req_valid = 2'b00;
        for (int k = 0; k < 40 && !seen; k++) begin @(negedge clk); seen = bready; end
        check("t6_reached_wresp", seen, 1);
        @(posedge clk); #3 rst_n = 0;
        d0 = done_cnt;
        #1 check("t6_async_drop", {awvalid, wvalid, bready, arvalid, rready, rsp_done}, 0);
        set_cmd(0, 1, 8'h30, 32'h0000_0030, 4'hF);
        set_cmd(1, 1, 8'h34, 32'h0000_0034, 4'hF);
        req_valid = 2'b11;
        sl_b_hold = 0;
        grant_log.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk); check("t6_tie_req0", req_ready, 2'b01);
        tick(); req_valid = 2'b10;
        wait_ready(1);
        tick(); req_valid = 2'b00;
        wait_idle();
        check("t6_done_count", done_cnt - d0, 2);
        check("t6_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    endtask

    task automatic run_random(input int cycles);
        logic [1:0] acc;
        int issued = 0;
        int d0 = done_cnt;
        sl_mode = 1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk); acc = req_ready;
            tick();
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && acc[i]) begin
                    issued++; req_valid[i] = 0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 0;
                    else if ($urandom_range(0, 7) == 0) req_wdata[i*32 +: 32] = $urandom;
                end
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_cmd(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15) * 4), $urandom, 4'($urandom_range(0, 15)));
                    req_valid[i] = 1;
                end
            end
        end
        @(negedge clk); acc = req_ready;
        tick();
        issued += int'(acc[0] & req_valid[0]) + int'(acc[1] & req_valid[1]);
        req_valid = 2'b00;
        wait_idle();
        check("random_issued_vs_done", done_cnt - d0, issued);
        check("random_activity", issued > 50, 1);
        sl_mode = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        test_basic();
        test_rr();
        test_aw_delay();
        test_rresp();
        test_reset();
        run_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
